// File: rtl/mem_pkg.sv
// Shared types and widths for the memory request scheduler.
//   ADDR_W / DATA_W : request address and data widths
//   state_t         : scheduler FSM states
//   req_t           : one queued host request {wr, addr, wdata}
package mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request FIFO.
//   clk, rst        : clock, async active-high reset (empties the queue)
//   push, push_data : enqueue when !full
//   pop             : dequeue head when !empty
//   head            : current head entry (combinational)
//   full, empty     : occupancy flags
module mem_req_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output req_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  req_t       mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  // Extra MSB on each pointer separates full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // full is the start-of-cycle flag, so a same-cycle pop never frees room for a push
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_req_sched.sv
// Memory request scheduler: queues host read/write requests and issues them
// one at a time to a memory controller, with a read timeout and an enforced
// idle gap after every command.
//   clk, rst                         : clock, async active-high reset
//   req_vld/req_rdy/req_wr/addr/wdata: host request channel
//   rsp_vld/rsp_rdata/rsp_err        : read response pulse (err = timed out)
//   wr_ack                           : write-issued pulse
//   cmd_n/RDnWR/Data_in_vld/Addr_in/Data_in : controller command side
//   Data_out/data_out_vld            : controller read data return
module mem_req_sched
  import mem_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_vld,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              wr_ack,
  output logic              cmd_n,
  output logic              RDnWR,
  output logic              Data_in_vld,
  output logic [ADDR_W-1:0] Addr_in,
  output logic [DATA_W-1:0] Data_in,
  input  logic [DATA_W-1:0] Data_out,
  input  logic              data_out_vld
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 7) ? $clog2(TIMEOUT + 1) : 7;
  localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

  state_t             state_q, state_d, after_cmd;
  req_t               req_in, head, hold_q;
  logic               full, empty, pop;
  logic               rdnwr_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               timeout, gap_done;

  assign req_in  = {req_wr, req_addr, req_wdata};
  assign req_rdy = !full;

  mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_vld),
    .push_data (req_in),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // wait_cnt is 0 during ISSUE and counts cycles since ISSUE; the timeout
  // response therefore lands exactly TIMEOUT cycles after the command.
  assign timeout   = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign gap_done  = (gap_cnt == GAP_W'(GAP_CYC - 1));
  assign after_cmd = (GAP_CYC == 0) ? S_IDLE : S_GAP;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE:   state_d = hold_q.wr ? after_cmd : S_RD_WAIT;
      S_RD_WAIT: if (data_out_vld || timeout) state_d = after_cmd;
      S_GAP:     if (gap_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      rdnwr_q   <= 1'b0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      rsp_vld   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        hold_q  <= head;
        rdnwr_q <= !head.wr;
      end
      if (pop)                                            wait_cnt <= '0;
      else if (state_q == S_ISSUE || state_q == S_RD_WAIT) wait_cnt <= wait_cnt + 1'b1;
      gap_cnt <= (state_q == S_GAP && state_d == S_GAP) ? gap_cnt + 1'b1 : '0;

      rsp_vld <= 1'b0;
      if (state_q == S_RD_WAIT) begin
        // real data wins over a timeout landing in the same cycle
        if (data_out_vld) begin
          rsp_vld   <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= Data_out;
        end else if (timeout) begin
          rsp_vld   <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
    end
  end

  // Command outputs decode from the state register and the hold register,
  // so they reach their idle values as soon as reset asserts.
  assign cmd_n       = (state_q != S_ISSUE);
  assign Data_in_vld = (state_q == S_ISSUE) && hold_q.wr;
  assign wr_ack      = (state_q == S_ISSUE) && hold_q.wr;
  assign RDnWR       = rdnwr_q;
  assign Addr_in     = hold_q.addr;
  assign Data_in     = hold_q.wdata;

endmodule

// File: tb/tb_mem_req_sched.sv
module tb_mem_req_sched;

  localparam int DEPTH   = 4;
  localparam int GAP_CYC = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0, req_rdy, req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_vld, rsp_err, wr_ack, cmd_n, RDnWR, Data_in_vld;
  logic [31:0] rsp_rdata, Data_in;
  logic [15:0] Addr_in;
  logic [31:0] Data_out = '0;
  logic        data_out_vld = 1'b0;

  mem_req_sched #(.DEPTH(DEPTH), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .wr_ack(wr_ack), .cmd_n(cmd_n), .RDnWR(RDnWR),
    .Data_in_vld(Data_in_vld), .Addr_in(Addr_in), .Data_in(Data_in),
    .Data_out(Data_out), .data_out_vld(data_out_vld)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s @cyc %0d: bound expired", nm, cyc);
  endtask

  // ---------------- behavioural model ----------------
  // Queue of accepted requests, plus time bookkeeping: when the scheduler
  // may next take a request (free_at) and when the held one is issued.
  typedef struct {
    bit        wr;
    bit [15:0] addr;
    bit [31:0] wdata;
  } mreq_t;

  mreq_t     mq[$];
  mreq_t     cur;
  bit        has_cur = 0, busy = 0;
  int        issue_cyc = -1, free_at = 0;
  bit        e_vld = 0, e_err = 0;
  bit [31:0] e_rdata = '0;

  always @(negedge clk) begin
    bit    exp_cmd, full_now;
    mreq_t m;
    if (rst) begin
      chk("rst_ctrl", {cmd_n, RDnWR, Data_in_vld, wr_ack, rsp_vld, rsp_err, req_rdy}, 7'b1000001);
      chk("rst_addr", Addr_in, 0);
      chk("rst_data", Data_in, 0);
      chk("rst_rdata", rsp_rdata, 0);
      mq.delete();
      has_cur = 0; busy = 0; issue_cyc = -1; free_at = 0;
      e_vld = 0; e_err = 0; e_rdata = '0;
    end else begin
      exp_cmd = busy && (cyc == issue_cyc);
      chk("cmd_n", cmd_n, !exp_cmd);
      chk("wr_ack", wr_ack, exp_cmd && cur.wr);
      chk("data_in_vld", Data_in_vld, exp_cmd && cur.wr);
      if (exp_cmd && cur.wr) chk("data_in", Data_in, cur.wdata);
      chk("addr_in", Addr_in, has_cur ? cur.addr : 16'h0);
      chk("rdnwr", RDnWR, has_cur ? !cur.wr : 1'b0);
      chk("req_rdy", req_rdy, mq.size() < DEPTH);
      chk("rsp_vld", rsp_vld, e_vld);
      if (e_vld) begin
        chk("rsp_err", rsp_err, e_err);
        chk("rsp_rdata", rsp_rdata, e_rdata);
      end

      full_now = (mq.size() == DEPTH);
      e_vld = 0;
      if (busy && cur.wr && cyc == issue_cyc) begin
        busy = 0;
        free_at = cyc + 1 + GAP_CYC;
      end else if (busy && !cur.wr && cyc > issue_cyc) begin
        if (data_out_vld) begin
          e_vld = 1; e_err = 0; e_rdata = Data_out;
          busy = 0; free_at = cyc + 1 + GAP_CYC;
        end else if (cyc - issue_cyc == TIMEOUT - 1) begin
          e_vld = 1; e_err = 1; e_rdata = '0;
          busy = 0; free_at = cyc + 1 + GAP_CYC;
        end
      end
      if (!busy && cyc >= free_at && mq.size() != 0) begin
        cur = mq.pop_front();
        has_cur = 1;
        busy = 1;
        issue_cyc = cyc + 1;
      end
      if (req_vld && !full_now) begin
        m.wr = req_wr; m.addr = req_addr; m.wdata = req_wdata;
        mq.push_back(m);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic wr, input logic [15:0] a, input logic [31:0] d);
    bit ok = 0;
    @(posedge clk); #1;
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_rdy === 1'b1) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    req_vld = 1'b0;
    if (!ok) fail_now("push_accept");
  endtask

  task automatic wait_cmd(input string nm, output int t);
    bit got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_n === 1'b0) begin got = 1; break; end
    end
    t = cyc;
    if (!got) fail_now(nm);
  endtask

  task automatic rand_run(input int ncyc, input int dpct, input int rst_at);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (i == rst_at) rst = 1'b1;
      else if (i == rst_at + 2) rst = 1'b0;
      req_vld      = !rst && ($urandom_range(99) < 40);
      req_wr       = 1'($urandom_range(1));
      req_addr     = 16'($urandom);
      req_wdata    = $urandom;
      data_out_vld = ($urandom_range(99) < dpct);
      Data_out     = $urandom;
    end
    @(posedge clk); #1;
    req_vld = 1'b0; data_out_vld = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int t, t2, r, n, acc, ngot, bad;
    bit seen_full, rdy;
    logic [15:0] got_a [6];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single write on an idle block: command two edges after acceptance
    push(1'b1, 16'h1001, 32'hA5A5A5A5);
    @(negedge clk);
    chk("wr_not_yet", cmd_n, 1'b1);
    @(negedge clk);
    chk("wr_issue", {cmd_n, RDnWR, Data_in_vld, wr_ack}, 4'b0011);
    chk("wr_data", Data_in, 32'hA5A5A5A5);
    chk("wr_addr", Addr_in, 16'h1001);
    @(negedge clk);
    chk("wr_pulse_end", {cmd_n, Data_in_vld, wr_ack}, 3'b100);

    // read with data 5 cycles after issue, then a queued write
    push(1'b0, 16'h1001, 32'h0);
    wait_cmd("rd_issue", t);
    chk("rd_issue", {RDnWR, Data_in_vld, Addr_in}, {1'b1, 1'b0, 16'h1001});
    push(1'b1, 16'h1002, 32'h12345678);
    while (cyc < t + 5) begin @(posedge clk); #1; end
    data_out_vld = 1'b1; Data_out = 32'hA5A5A5A5;
    @(posedge clk); #1;
    data_out_vld = 1'b0;
    @(negedge clk);
    r = cyc;
    chk("rd_rsp", {rsp_vld, rsp_err}, 2'b10);
    chk("rd_rdata", rsp_rdata, 32'hA5A5A5A5);
    wait_cmd("rd_next", t2);
    chk("rd_gap", (t2 - r) >= GAP_CYC + 1, 1'b1);

    // read that times out, then late data must be ignored
    push(1'b0, 16'h2222, 32'h0);
    wait_cmd("to_issue", t);
    n = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_vld === 1'b1) begin n = cyc - t; break; end
    end
    chk("to_latency", n, 64);
    chk("to_rsp", {rsp_err, rsp_rdata}, {1'b1, 32'h0});
    @(posedge clk); #1;
    data_out_vld = 1'b1; Data_out = 32'hDEADBEEF;
    @(posedge clk); #1;
    data_out_vld = 1'b0;
    bad = 0;
    repeat (6) begin @(negedge clk); if (rsp_vld !== 1'b0) bad++; end
    chk("late_data_ignored", bad, 0);

    // six back-to-back writes behind a stalled read
    push(1'b0, 16'h2000, 32'h0);
    wait_cmd("stall_rd", t);
    acc = 0; ngot = 0; seen_full = 0;
    for (int k = 0; k < 6; k++) got_a[k] = '0;
    @(posedge clk); #1;
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 16'h3000; req_wdata = $urandom;
    for (int i = 0; i < 400 && acc < 6; i++) begin
      @(negedge clk);
      if (cmd_n === 1'b0 && ngot < 6) begin got_a[ngot] = Addr_in; ngot++; end
      if (acc == 4 && !seen_full) begin seen_full = 1; chk("full_after_4", req_rdy, 1'b0); end
      rdy = req_rdy;
      @(posedge clk); #1;
      if (rdy) begin
        acc++;
        req_addr = 16'(16'h3000 + acc);
        req_wdata = $urandom;
      end
    end
    req_vld = 1'b0;
    if (acc < 6) fail_now("burst_accept");
    for (int i = 0; i < 600 && ngot < 6; i++) begin
      @(negedge clk);
      if (cmd_n === 1'b0) begin got_a[ngot] = Addr_in; ngot++; end
    end
    for (int k = 0; k < 6; k++) chk("burst_order", got_a[k], 16'(16'h3000 + k));

    // reset during a stalled read with three queued requests
    push(1'b0, 16'h4000, 32'h0);
    wait_cmd("rst_rd", t);
    push(1'b1, 16'h4100, 32'h1);
    push(1'b1, 16'h4101, 32'h2);
    push(1'b1, 16'h4102, 32'h3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {cmd_n, rsp_vld, Data_in_vld, Addr_in}, {1'b1, 1'b0, 1'b0, 16'h0});
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", req_rdy, 1'b1);
    bad = 0;
    repeat (80) begin @(negedge clk); if (rsp_vld !== 1'b0 || cmd_n !== 1'b1) bad++; end
    chk("no_activity_after_rst", bad, 0);
    push(1'b1, 16'h7777, 32'h77);
    wait_cmd("post_rst_issue", t);
    chk("post_rst_first", Addr_in, 16'h7777);

    // randomized traffic against the model
    rand_run(2000, 30, -10);
    rand_run(1500, 0, -10);
    rand_run(1500, 5, 700);
    repeat (200) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_req_sched.md
MEM_REQ_SCHED -- requirements
Module: mem_req_sched

Interface
REQ-001 SHALL have parameter DEPTH, 4, request queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter GAP_CYC, 4, idle cycles enforced after every command before the next.
REQ-003 SHALL have parameter TIMEOUT, 64, max cycles a read waits for data_out_vld.
REQ-004 SHALL have a single clock and an asynchronous, active-high reset.
REQ-005 SHALL have ports:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous reset, active-high
  req_vld  in  1  host request valid
  req_rdy  out  1  queue can accept
  req_wr  in  1  1=write, 0=read
  req_addr  in  16  request address
  req_wdata  in  32  write data
  rsp_vld  out  1  one-cycle read-response pulse
  rsp_rdata  out  32  read data
  rsp_err  out  1  read timed out (valid with rsp_vld)
  wr_ack  out  1  one-cycle write-issued pulse
  cmd_n  out  1  controller command strobe, active-low
  RDnWR  out  1  1=read, 0=write to controller
  Data_in_vld  out  1  write data valid to controller
  Addr_in  out  16  address to controller
  Data_in  out  32  write data to controller
  Data_out  in  32  read data from controller
  data_out_vld  in  1  read data valid from controller

Function
REQ-006 SHALL accept a request on a rising edge where req_vld=1 and req_rdy=1, storing {wr, addr, wdata} in an in-order FIFO.
REQ-007 SHALL drive req_rdy = !full; a push with FIFO full SHALL be refused even if a pop occurs in that same cycle.
REQ-008 SHALL run an FSM with states IDLE, ISSUE, RD_WAIT, GAP.
REQ-009 IDLE: if FIFO non-empty, pop head into a hold register -> ISSUE; else stay.
REQ-010 ISSUE (exactly one cycle): cmd_n=0, RDnWR=hold.wr?0:1, Addr_in=hold.addr; for writes also Data_in_vld=1, Data_in=hold.wdata, wr_ack=1; write -> GAP, read -> RD_WAIT.
REQ-011 Addr_in and RDnWR SHALL stay stable from ISSUE through the last cycle of RD_WAIT and GAP; Data_in_vld and cmd_n SHALL be deasserted outside ISSUE.
REQ-012 With queue empty and FSM idle, cmd_n SHALL go low in the second cycle after acceptance (acceptance edge N, ISSUE during cycle N+2).
REQ-013 RD_WAIT: on data_out_vld=1, register Data_out to rsp_rdata, pulse rsp_vld with rsp_err=0, -> GAP.
REQ-014 RD_WAIT: a 7-bit+ wait counter cleared in ISSUE; if TIMEOUT cycles elapse without data_out_vld, pulse rsp_vld with rsp_err=1, rsp_rdata=0, -> GAP.
REQ-015 data_out_vld outside RD_WAIT (including late data after timeout) SHALL be ignored.
REQ-016 GAP: count GAP_CYC cycles, then -> IDLE; GAP_CYC=0 SHALL go directly to IDLE.
REQ-017 Acceptance SHALL continue in every FSM state while not full; FIFO pointers wrap modulo DEPTH with an extra wrap bit for full/empty.
REQ-018 Responses SHALL be in request order; rsp_vld has no backpressure.

Reset
REQ-019 On rst=1, outputs SHALL asynchronously become: cmd_n=1, RDnWR=0, Data_in_vld=0, Addr_in=0, Data_in=0, rsp_vld=0, rsp_rdata=0, rsp_err=0, wr_ack=0; FIFO empty; FSM=IDLE; counters 0.
REQ-020 Reset mid-operation SHALL discard all queued and in-flight requests with no response; req_rdy=1 in the first cycle after rst deasserts.

Structure
REQ-021 Package mem_pkg SHALL hold the FSM state enum, the request struct typedef {wr, addr[15:0], wdata[31:0]}, and widths ADDR_W=16, DATA_W=32.
REQ-022 The FIFO SHALL be the sub-module mem_req_fifo (parameterised DEPTH, push/pop/full/empty).

Verification
REQ-023 Single write addr 0x1001 data 0xA5A5A5A5 on idle block -> cmd_n=0, RDnWR=0, Data_in_vld=1, Data_in=0xA5A5A5A5, wr_ack=1 for exactly one cycle, 2 cycles after acceptance.
REQ-024 Read addr 0x1001, model returns 0xA5A5A5A5 on data_out_vld 5 cycles after ISSUE -> rsp_vld=1, rsp_err=0, rsp_rdata=0xA5A5A5A5; next cmd_n low no earlier than GAP_CYC+1 cycles later.
REQ-025 Read with data_out_vld never asserted -> rsp_vld=1, rsp_err=1, rsp_rdata=0 exactly 64 cycles after ISSUE; data_out_vld pulsed afterwards -> no rsp_vld.
REQ-026 Push 6 back-to-back requests during a stalled read -> req_rdy falls after 4 stored; all issue in order, Addr_in sequence matches push order.
REQ-027 Assert rst during RD_WAIT with 3 queued -> cmd_n=1 immediately, no rsp_vld after release, req_rdy=1, next pushed request is the first issued.
